// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM state type, datapath widths and playfield edge constants
// for the pong game sequencer.
package pong_pkg;
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT, OVER} state_e;
  localparam int POS_W = 4;
  localparam int SPEED_W = 5;
  localparam logic [POS_W-1:0] X_LEFT = 4'd0;
  localparam logic [POS_W-1:0] X_RIGHT = 4'd15;
  function automatic logic [POS_W:0] abs_diff(input logic [POS_W-1:0] a, input logic [POS_W-1:0] b);
    return a >= b ? {1'b0, a} - {1'b0, b} : {1'b0, b} - {1'b0, a};
  endfunction
endpackage

// File: rtl/rally_ctrl_pause_timer.sv
// pause_timer: loadable down-counter; done is high while enabled and the count
// has reached zero.
module pause_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else if (load) cnt_q <= load_val;
    else if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
  assign done = en && cnt_q == '0;
endmodule

// File: rtl/rally_ctrl.sv
// rally_ctrl: pong game sequencer: serve, hit/miss, scoring, pauses, ball control.
// Define RALLY_SPEED_RAMP_EN to ramp ball speed with paddle hits.
module rally_ctrl
  import pong_pkg::*;
#(
  parameter int START_SPEED   = 4,
  parameter int MAX_SPEED     = 15,
  parameter int HITS_PER_STEP = 4,
  parameter int SERVE_HOLD    = 1000,
  parameter int POINT_PAUSE   = 2000,
  parameter int WIN_SCORE     = 9,
  parameter int PADDLE_HALF   = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      serve,
  input  logic [POS_W-1:0]          paddle_l,
  input  logic [POS_W-1:0]          paddle_r,
  input  logic [POS_W-1:0]          ball_x,
  input  logic [POS_W-1:0]          ball_y,
  output logic                      ball_reset,
  output logic signed [SPEED_W-1:0] ball_speed,
  output logic [POS_W-1:0]          score_l,
  output logic [POS_W-1:0]          score_r,
  output logic                      game_over,
  output logic [2:0]                state
);
  localparam int PMAX = SERVE_HOLD > POINT_PAUSE ? SERVE_HOLD : POINT_PAUSE;
  localparam int TW = PMAX > 1 ? $clog2(PMAX) : 1;
  localparam logic signed [SPEED_W-1:0] START = SPEED_W'(START_SPEED);

  if (MAX_SPEED < START_SPEED || MAX_SPEED > 15 || HITS_PER_STEP < 1) begin : g_bad_param
    $error("rally_ctrl: invalid speed parameters");
  end

  state_e state_q, state_d;
  logic [POS_W-1:0] prev_x_q, score_l_q, score_l_d, score_r_q, score_r_d;
  logic serve_dir_q, serve_dir_d, ball_reset_q, ball_reset_d, game_over_q, game_over_d;
  logic signed [SPEED_W-1:0] speed_q, speed_d, serve_speed;
  logic ev_l, ev_r, miss_l, miss_r, win, restart, serve_in, t_load, t_done;
  logic [TW-1:0] t_val;

  // Events fire only on arrival at an edge column; staying there does not re-fire.
  assign ev_l = state_q == PLAY && ball_x == X_LEFT && prev_x_q != X_LEFT;
  assign ev_r = state_q == PLAY && ball_x == X_RIGHT && prev_x_q != X_RIGHT;
  assign miss_l = ev_l && abs_diff(ball_y, paddle_l) > (POS_W+1)'(PADDLE_HALF);
  assign miss_r = ev_r && abs_diff(ball_y, paddle_r) > (POS_W+1)'(PADDLE_HALF);
  assign win = score_l_d == POS_W'(WIN_SCORE) || score_r_d == POS_W'(WIN_SCORE);
  assign restart = state_q == OVER && serve;
  assign serve_in = state_d == SERVE && state_q != SERVE;
  assign t_load = serve_in || (state_d == POINT && state_q != POINT);
  assign t_val = state_d == SERVE ? TW'(SERVE_HOLD - 1) : TW'(POINT_PAUSE - 1);

  pause_timer #(.W(TW)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(t_load),
    .en(state_q == SERVE || state_q == POINT),
    .load_val(t_val),
    .done(t_done)
  );

  always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = serve ? SERVE : IDLE;
      SERVE:   state_d = t_done ? PLAY : SERVE;
      PLAY:    state_d = !(miss_l || miss_r) ? PLAY : win ? OVER : POINT;
      POINT:   state_d = t_done ? SERVE : POINT;
      OVER:    state_d = serve ? SERVE : OVER;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    score_l_d = restart ? '0 : score_l_q + POS_W'(miss_r);
    score_r_d = restart ? '0 : score_r_q + POS_W'(miss_l);
    serve_dir_d = (restart || miss_l) ? 1'b0 : miss_r ? 1'b1 : serve_dir_q;
    serve_speed = serve_dir_d ? -START : START;
    ball_reset_d = state_d != PLAY;
    game_over_d = state_d == OVER;
  end

`ifdef RALLY_SPEED_RAMP_EN
  localparam int HW = HITS_PER_STEP > 1 ? $clog2(HITS_PER_STEP) : 1;
  logic [HW-1:0] hit_cnt_q, hit_cnt_d;
  logic [SPEED_W-1:0] mag;
  logic hit, step;
  assign hit = (ev_l || ev_r) && !(miss_l || miss_r);
  assign step = hit && hit_cnt_q == HW'(HITS_PER_STEP - 1);
  assign mag = speed_q[SPEED_W-1] ? SPEED_W'(-speed_q) : SPEED_W'(speed_q);
  // The ball reflects itself, so a step only grows the magnitude and keeps the sign.
  always_comb begin
    hit_cnt_d = (miss_l || miss_r || step) ? '0 : hit_cnt_q + HW'(hit);
    speed_d = serve_in ? serve_speed
            : !(step && mag < SPEED_W'(MAX_SPEED)) ? speed_q
            : speed_q[SPEED_W-1] ? speed_q - SPEED_W'(1) : speed_q + SPEED_W'(1);
  end
  always_ff @(posedge clk) hit_cnt_q <= reset ? '0 : hit_cnt_d;
`else
  assign speed_d = serve_in ? serve_speed : speed_q;
`endif

  always_ff @(posedge clk)
    if (reset) begin
      prev_x_q <= POS_W'(8);
      score_l_q <= '0;
      score_r_q <= '0;
      serve_dir_q <= 1'b0;
      speed_q <= START;
      ball_reset_q <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      prev_x_q <= ball_x;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      serve_dir_q <= serve_dir_d;
      speed_q <= speed_d;
      ball_reset_q <= ball_reset_d;
      game_over_q <= game_over_d;
    end

  assign ball_reset = ball_reset_q;
  assign ball_speed = speed_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;
  assign game_over = game_over_q;
  assign state = state_q;
endmodule
